// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end definitions: bundle field widths and packing offsets
// used by the dispatch queue and the reservation station.
package ooo_pkg;

    localparam int FormatWidth             = 25;
    localparam int opcodeSize              = 12;
    localparam int addressWidth            = 64;
    localparam int funcUnitCodeSize        = 3;
    localparam int instructionCounterWidth = 64;
    localparam int instMinIdWidth          = 7;
    localparam int Is64BitWidth            = 1;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int regAccessPatternSize    = 8;
    localparam int RegIsRegWidth           = 4;
    localparam int BodyWidth               = 84;

    // Fields are packed LSB-up starting with the body; format sits at the MSB end.
    localparam int BodyOffset     = 0;
    localparam int IsRegOffset    = BodyOffset + BodyWidth;
    localparam int RwOffset       = IsRegOffset + RegIsRegWidth;
    localparam int TidOffset      = RwOffset + regAccessPatternSize;
    localparam int PidOffset      = TidOffset + TidSize;
    localparam int Is64BitOffset  = PidOffset + PidSize;
    localparam int MinIdOffset    = Is64BitOffset + Is64BitWidth;
    localparam int MajIdOffset    = MinIdOffset + instMinIdWidth;
    localparam int FuncUnitOffset = MajIdOffset + instructionCounterWidth;
    localparam int AddressOffset  = FuncUnitOffset + funcUnitCodeSize;
    localparam int OpcodeOffset   = AddressOffset + addressWidth;
    localparam int FormatOffset   = OpcodeOffset + opcodeSize;
    localparam int PayloadWidth   = FormatOffset + FormatWidth;

    typedef logic [PayloadWidth-1:0] bundle_t;

    function automatic logic [instructionCounterWidth-1:0] get_maj_id(input bundle_t bundle);
        return bundle[MajIdOffset +: instructionCounterWidth];
    endfunction

endpackage

// File: rtl/dispatch_queue_mem.sv
// Dispatch queue storage: one synchronous write port, one asynchronous read port.
module dispatch_queue_mem #(
    parameter int IdxBits = 3,
    parameter int Width   = 308
) (
    input  logic               clock_i,
    input  logic               wr_en,
    input  logic [IdxBits-1:0] wr_addr,
    input  logic [Width-1:0]   wr_data,
    input  logic [IdxBits-1:0] rd_addr,
    output logic [Width-1:0]   rd_data
);

    localparam int Depth = 1 << IdxBits;

    logic [Width-1:0] storage [Depth];

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    assign rd_data = storage[rd_addr];

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the reservation station, with
// registered stall back-pressure and a sticky overflow flag for dropped pushes.
module dispatch_queue #(
    parameter int QueueIdxBits = 3,
    parameter int PayloadWidth = ooo_pkg::PayloadWidth,
    parameter int StallMargin  = 2,
    parameter int DQInstance   = 0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [PayloadWidth-1:0] inst_i,
    input  logic                    flush_i,
    input  logic                    rsFull_i,
    output logic                    stall_o,
    output logic                    enable_o,
    output logic [PayloadWidth-1:0] inst_o,
    output logic [QueueIdxBits:0]   count_o,
    output logic                    overflow_o
);

    import ooo_pkg::*;

    localparam logic [QueueIdxBits:0]   DepthCount = (QueueIdxBits+1)'(1 << QueueIdxBits);
    localparam logic [QueueIdxBits:0]   StallCount = (QueueIdxBits+1)'(StallMargin);
    localparam logic [QueueIdxBits:0]   CountOne   = (QueueIdxBits+1)'(1);
    localparam logic [QueueIdxBits-1:0] PtrOne     = QueueIdxBits'(1);

    if (PayloadWidth != ooo_pkg::PayloadWidth) begin : g_width_check
        $error("dispatch_queue: PayloadWidth must match the ooo_pkg bundle packing");
    end
    if (DQInstance < 0) begin : g_instance_check
        $error("dispatch_queue: DQInstance must be non-negative");
    end

    logic [QueueIdxBits-1:0] rd_ptr_q;
    logic [QueueIdxBits-1:0] wr_ptr_q;
    logic [QueueIdxBits:0]   count_q;
    logic [QueueIdxBits:0]   count_next;
    logic                    stall_q;
    logic                    overflow_q;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    mem_wr_en;

    assign full      = (count_q == DepthCount);
    assign enable_o  = (count_q != '0);
    assign pop       = enable_o && !rsFull_i;
    assign push      = enable_i && (!full || pop);
    assign drop      = enable_i && full && !pop && !flush_i;
    assign mem_wr_en = push && !flush_i && !reset_i;

    always_comb begin
        count_next = count_q;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + CountOne;
        end else if (pop && !push) begin
            count_next = count_q - CountOne;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_next;
            // Stall looks at free space after this cycle's update, so decode sees it one cycle early.
            stall_q <= (DepthCount - count_next) < StallCount;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    dispatch_queue_mem #(
        .IdxBits (QueueIdxBits),
        .Width   (PayloadWidth)
    ) u_mem (
        .clock_i (clock_i),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (inst_i),
        .rd_addr (rd_ptr_q),
        .rd_data (inst_o)
    );

    assign count_o    = count_q;
    assign stall_o    = stall_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dispatch_queue;

    localparam int PW     = ooo_pkg::PayloadWidth;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int MOFF   = ooo_pkg::MajIdOffset;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          enable_i = 1'b0;
    logic [PW-1:0] inst_i = '0;
    logic          flush_i = 1'b0;
    logic          rsFull_i = 1'b0;
    logic          stall_o;
    logic          enable_o;
    logic [PW-1:0] inst_o;
    logic [3:0]    count_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [PW-1:0] mq[$];
    logic [63:0]   mlog[$];
    bit            m_ovf = 0;
    bit            m_stall = 0;

    dispatch_queue dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .inst_i     (inst_i),
        .flush_i    (flush_i),
        .rsFull_i   (rsFull_i),
        .stall_o    (stall_o),
        .enable_o   (enable_o),
        .inst_o     (inst_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [63:0] maj);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = 1'($urandom_range(0, 1));
        b[MOFF +: 64] = maj;
        return b;
    endfunction

    task automatic step(input logic en, input logic [63:0] maj, input logic fl,
                        input logic full, input logic rst = 1'b0);
        enable_i = en;
        inst_i   = mk(maj);
        flush_i  = fl;
        rsFull_i = full;
        reset_i  = rst;
        @(negedge clock_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (count_o != 0) step(1'b0, 64'd0, 1'b0, 1'b0);
        end
        chk("drain_count", PW'(count_o), PW'(0));
    endtask

    // Reference model: plain FIFO semantics applied at each rising edge.
    always @(posedge clock_i) begin
        int sz;
        bit pop, push;
        sz = mq.size();
        if (reset_i) begin
            mq.delete();
            m_ovf   = 0;
            m_stall = 0;
        end else begin
            pop  = (sz != 0) && !rsFull_i;
            push = enable_i && ((sz < DEPTH) || pop);
            if (flush_i) begin
                mq.delete();
            end else begin
                if (pop) begin
                    mlog.push_back(mq[0][MOFF +: 64]);
                    void'(mq.pop_front());
                end
                if (push) mq.push_back(inst_i);
                else if (enable_i) m_ovf = 1;
            end
            m_stall = (DEPTH - mq.size()) < MARGIN;
        end
    end

    always @(negedge clock_i) begin
        if (started) begin
            chk("count", PW'(count_o), PW'(mq.size()));
            chk("enable", PW'(enable_o), PW'(mq.size() != 0));
            chk("stall", PW'(stall_o), PW'(m_stall));
            chk("overflow", PW'(overflow_o), PW'(m_ovf));
            if (mq.size() != 0) chk("inst", inst_o, mq[0]);
        end
    end

    initial begin
        int max_cnt;
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'd77, 1'b1, 1'b1, 1'b1);
        started = 1;
        chk("rst_count", PW'(count_o), PW'(0));
        chk("rst_enable", PW'(enable_o), PW'(0));
        chk("rst_stall", PW'(stall_o), PW'(0));
        chk("rst_ovf", PW'(overflow_o), PW'(0));

        // Three pushes with free-flowing reservation station
        step(1'b1, 64'd1, 1'b0, 1'b0);
        chk("p1_enable", PW'(enable_o), PW'(1));
        chk("p1_head", PW'(inst_o[MOFF +: 64]), PW'(1));
        step(1'b1, 64'd2, 1'b0, 1'b0);
        step(1'b1, 64'd3, 1'b0, 1'b0);
        drain();
        chk("p1_log_size", PW'(mlog.size()), PW'(3));
        for (int i = 0; i < 3; i++) chk("p1_log", PW'(mlog[i]), PW'(i + 1));
        mlog.delete();

        // Fill with the station full, then overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 1'b0, 1'b1);
            if (i == 6) chk("p2_stall6", PW'(stall_o), PW'(0));
            if (i == 7) chk("p2_stall7", PW'(stall_o), PW'(1));
        end
        chk("p2_count", PW'(count_o), PW'(8));
        chk("p2_ovf0", PW'(overflow_o), PW'(0));
        step(1'b1, 64'd99, 1'b0, 1'b1);
        chk("p2_ovf1", PW'(overflow_o), PW'(1));
        chk("p2_count9", PW'(count_o), PW'(8));
        chk("p2_head", PW'(inst_o[MOFF +: 64]), PW'(1));

        // Push and pop together while full
        step(1'b1, 64'd100, 1'b0, 1'b0);
        chk("p3_count", PW'(count_o), PW'(8));
        chk("p3_head", PW'(inst_o[MOFF +: 64]), PW'(2));
        drain();
        chk("p3_log_size", PW'(mlog.size()), PW'(9));
        chk("p3_tail", PW'(mlog[8]), PW'(100));
        mlog.delete();

        // Continuous stream through wrapping pointers
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 64'(200 + i), 1'b0, 1'b0);
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
        end
        drain();
        chk("p4_max_count", PW'(max_cnt), PW'(1));
        chk("p4_log_size", PW'(mlog.size()), PW'(20));
        for (int i = 0; i < 20; i++) chk("p4_order", PW'(mlog[i]), PW'(200 + i));
        mlog.delete();

        // Flush beats a same-cycle push
        for (int i = 0; i < 5; i++) step(1'b1, 64'(300 + i), 1'b0, 1'b1);
        chk("p5_count5", PW'(count_o), PW'(5));
        step(1'b1, 64'd305, 1'b1, 1'b1);
        chk("p5_count0", PW'(count_o), PW'(0));
        chk("p5_enable0", PW'(enable_o), PW'(0));
        step(1'b1, 64'd306, 1'b0, 1'b1);
        chk("p5_head", PW'(inst_o[MOFF +: 64]), PW'(306));
        drain();
        mlog.delete();

        // Reset mid-operation overrides everything
        for (int i = 0; i < 4; i++) step(1'b1, 64'(400 + i), 1'b0, 1'b1);
        chk("p6_count4", PW'(count_o), PW'(4));
        step(1'b1, 64'd499, 1'b1, 1'b1, 1'b1);
        chk("p6_count", PW'(count_o), PW'(0));
        chk("p6_enable", PW'(enable_o), PW'(0));
        chk("p6_stall", PW'(stall_o), PW'(0));
        chk("p6_ovf", PW'(overflow_o), PW'(0));
        step(1'b1, 64'd9, 1'b0, 1'b1);
        chk("p6_head", PW'(inst_o[MOFF +: 64]), PW'(9));
        drain();
        chk("p6_first_out", PW'(mlog.size() > 0 ? mlog[0] : 64'hdead), PW'(9));

        step(1'b0, 64'd0, 1'b0, 1'b0);
        started = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter QueueIdxBits, default 3, log2 of queue depth (8 entries).
REQ-002 Parameter PayloadWidth, default 308, packed instruction bundle width; field order is fixed in the shared package.
REQ-003 Parameter StallMargin, default 2, free-entry threshold for upstream stall.
REQ-004 Parameter DQInstance, default 0, instance number selecting the debug log file.
REQ-005 clock_i  in  1  single clock; all state SHALL update on posedge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 enable_i  in  1  upstream decode presents a valid bundle this cycle.
REQ-008 inst_i  in  PayloadWidth  bundle: format 25, opcode 12, address 64, funcUnitType 3, majID 64, minID 7, is64Bit 1, pid 20, tid 16, op1-4 rw 8, op1-4 isReg 4, body 84.
REQ-009 flush_i  in  1  discard all queued entries (mispredict/exception).
REQ-010 rsFull_i  in  1  reservation station isFull; when high, the head SHALL NOT transfer.
REQ-011 stall_o  out  1  registered back-pressure to decode.
REQ-012 enable_o  out  1  head bundle valid toward the reservation station.
REQ-013 inst_o  out  PayloadWidth  head bundle, same packing as inst_i.
REQ-014 count_o  out  QueueIdxBits+1  current occupancy, 0..2**QueueIdxBits.
REQ-015 overflow_o  out  1  sticky error: a push was dropped.

Function
REQ-016 Circular FIFO of 2**QueueIdxBits entries; read/write pointers QueueIdxBits wide and SHALL wrap modulo depth; full/empty SHALL be derived from count, not pointer equality.
REQ-017 Pop occurs when enable_o && !rsFull_i; the head entry is consumed that cycle.
REQ-018 Push occurs when enable_i && (count < depth || pop); data is written at the write pointer and is first visible on enable_o/inst_o the following cycle. There is no same-cycle bypass when empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-020 enable_i while full with no pop SHALL drop the bundle, leave all state unchanged, and set overflow_o (sticky until reset).
REQ-021 enable_o SHALL equal (count != 0); inst_o SHALL hold the head entry and stay stable while rsFull_i is high.
REQ-022 stall_o SHALL be registered, high in cycle N+1 iff the post-update free count at N is < StallMargin, giving decode one cycle of slack.
REQ-023 flush_i SHALL zero count and both pointers next cycle; flush SHALL take priority over a same-cycle push and pop. overflow_o SHALL be unaffected by flush.
REQ-024 Every accepted push SHALL be popped exactly once, in order; majID order at output SHALL match input order.
REQ-025 Under DEBUG_PRINT, push, pop, drop and flush events SHALL be logged to DispatchQueue<DQInstance>.log.

Reset
REQ-026 While reset_i is high at posedge: pointers=0, count_o=0, enable_o=0, stall_o=0, overflow_o=0; storage contents are don't-care.
REQ-027 Reset SHALL override flush_i, enable_i and rsFull_i. Reset mid-operation SHALL discard all entries, and no stale bundle SHALL appear afterwards.

Structure
REQ-028 Shared package ooo_pkg SHALL hold the field widths (opcodeSize, addressWidth, funcUnitCodeSize=3, instructionCounterWidth, instMinIdWidth, PidSize, TidSize, regAccessPatternSize), PayloadWidth, and the field offset constants used by both this block and the reservation station.
REQ-029 Storage SHALL be one sub-module, dispatch_queue_mem (1 write port, 1 async read port, depth 2**QueueIdxBits). Pointer, count and control logic stay in dispatch_queue.

Verification
REQ-030 Reset, then push majID 1..3 with rsFull_i=0 -> enable_o high from cycle after the first push; inst_o majIDs 1,2,3 in order; count_o returns to 0.
REQ-031 rsFull_i=1, push 8 bundles -> count_o=8; stall_o high the cycle after count reaches 7; 9th push dropped, overflow_o=1, head still majID 1.
REQ-032 Full queue, rsFull_i=0 and enable_i=1 in the same cycle -> count stays 8; the new bundle lands at the tail; no overflow.
REQ-033 Push/pop 20 bundles continuously -> pointers wrap twice; output majID sequence identical to input; count_o never exceeds 1.
REQ-034 count_o=5, flush_i=1 with enable_i=1 -> next cycle count_o=0, enable_o=0, pushed bundle absent.
REQ-035 count_o=4, assert reset_i one cycle -> all outputs at reset values next cycle; subsequent push of majID 9 is the first output.
